// File: rtl/boot_load_ctrl_if.sv
// UART-side strobes and instruction-memory / core-control bundle
// for the boot loader sequencer.
interface boot_load_ctrl_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  reload;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_rst_n;
  logic [3:0]            led;
  logic [ADDR_WIDTH:0]   word_count;

  modport master (
    output rx_data, rx_valid, reload,
    input  imem_we, imem_addr, imem_wdata,
    input  cpu_rst_n, led, word_count
  );

  modport slave (
    input  rx_data, rx_valid, reload,
    output imem_we, imem_addr, imem_wdata,
    output cpu_rst_n, led, word_count
  );
endinterface

// File: rtl/boot_load_ctrl.sv
// Boot loader: length-prefixed UART image -> imem, then core release.
// Optional trailing XOR checksum byte: define BOOT_LOAD_CHECKSUM_EN.
module boot_load_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input logic             CLK,
  input logic             RST_N,
  boot_load_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_LOAD = 3'd1,
`ifdef BOOT_LOAD_CHECKSUM_EN
    ST_CHK  = 3'd2,
`endif
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

`ifdef BOOT_LOAD_CHECKSUM_EN
  localparam state_t ST_DONE = ST_CHK;
`else
  localparam state_t ST_DONE = ST_RUN;
`endif

  state_t                r_state;
  logic [1:0]            r_bcnt;
  logic [23:0]           r_asm;
  logic [31:0]           r_n;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH:0]   r_wc;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_cpu_rst_n;
  logic [3:0]            r_led;

  state_t                w_state_nxt;
  logic [1:0]            w_bcnt_nxt;
  logic [23:0]           w_asm_nxt;
  logic [31:0]           w_n_nxt;
  logic [ADDR_WIDTH-1:0] w_idx_nxt;
  logic [ADDR_WIDTH:0]   w_wc_nxt;
  logic                  w_we_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [31:0]           w_wdata_nxt;
  logic                  w_cpu_nxt;
  logic [3:0]            w_led_nxt;

  logic [31:0]           w_word;
  logic [ADDR_WIDTH:0]   w_wc_inc;
  logic                  w_last;

`ifdef BOOT_LOAD_CHECKSUM_EN
  logic [7:0]            r_xor;
  logic [7:0]            w_xor_nxt;
`endif

  assign w_word   = {r_asm, bus.rx_data};
  assign w_wc_inc = r_wc + 1'b1;
  assign w_last   = (32'(w_wc_inc) == r_n);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_HDR;
    else        r_state <= w_state_nxt;
  end

  // Next-state, byte assembly and write-port computation
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_asm_nxt   = r_asm;
    w_n_nxt     = r_n;
    w_idx_nxt   = r_idx;
    w_wc_nxt    = r_wc;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
`ifdef BOOT_LOAD_CHECKSUM_EN
    w_xor_nxt   = r_xor;
`endif
    if (bus.reload) begin
      w_state_nxt = ST_HDR;
      w_bcnt_nxt  = 2'd0;
      w_idx_nxt   = '0;
      w_wc_nxt    = '0;
      w_addr_nxt  = '0;
`ifdef BOOT_LOAD_CHECKSUM_EN
      w_xor_nxt   = 8'd0;
`endif
    end else begin
      unique case (r_state)
        ST_HDR: begin
          if (bus.rx_valid) begin
            w_asm_nxt  = w_word[23:0];
            w_bcnt_nxt = r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              w_n_nxt = w_word;
              if (w_word == 32'd0)
                w_state_nxt = ST_DONE;
              else if ({1'b0, w_word} > CAP)
                w_state_nxt = ST_ERR;
              else
                w_state_nxt = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (bus.rx_valid) begin
            w_asm_nxt  = w_word[23:0];
            w_bcnt_nxt = r_bcnt + 2'd1;
`ifdef BOOT_LOAD_CHECKSUM_EN
            w_xor_nxt  = r_xor ^ bus.rx_data;
`endif
            if (r_bcnt == 2'd3) begin
              w_we_nxt    = 1'b1;
              w_addr_nxt  = r_idx;
              w_wdata_nxt = w_word;
              w_idx_nxt   = r_idx + 1'b1;
              w_wc_nxt    = w_wc_inc;
              if (w_last) w_state_nxt = ST_DONE;
            end
          end
        end
`ifdef BOOT_LOAD_CHECKSUM_EN
        ST_CHK: begin
          if (bus.rx_valid) begin
            w_bcnt_nxt  = r_bcnt + 2'd1;
            w_state_nxt = (bus.rx_data == r_xor) ? ST_RUN : ST_ERR;
          end
        end
`endif
        default: ;
      endcase
    end
    w_cpu_nxt = !bus.reload && (r_state == ST_RUN);
    unique case (w_state_nxt)
      ST_HDR:  w_led_nxt = 4'b0001;
      ST_LOAD: w_led_nxt = 4'b0010;
`ifdef BOOT_LOAD_CHECKSUM_EN
      ST_CHK:  w_led_nxt = 4'b0100;
`endif
      ST_RUN:  w_led_nxt = 4'b1000;
      default: w_led_nxt = 4'b1111;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bcnt      <= 2'd0;
      r_asm       <= '0;
      r_n         <= '0;
      r_idx       <= '0;
      r_wc        <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rst_n <= 1'b0;
      r_led       <= 4'b0001;
    end else begin
      r_bcnt      <= w_bcnt_nxt;
      r_asm       <= w_asm_nxt;
      r_n         <= w_n_nxt;
      r_idx       <= w_idx_nxt;
      r_wc        <= w_wc_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_cpu_rst_n <= w_cpu_nxt;
      r_led       <= w_led_nxt;
    end
  end

`ifdef BOOT_LOAD_CHECKSUM_EN
  // Running XOR over payload bytes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_xor <= 8'd0;
    else        r_xor <= w_xor_nxt;
  end
`endif

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_rst_n  = r_cpu_rst_n;
  assign bus.led        = r_led;
  assign bus.word_count = r_wc;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Scoreboard bench for boot_load_ctrl: randomized images,
// reload/reset interruptions and capacity boundaries.
module tb_boot_load_ctrl;
  localparam int AW = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  wr_t  sb[$];
  int   wr_cyc[$];

  boot_load_ctrl_if #(.ADDR_WIDTH(AW)) bus();

  boot_load_ctrl #(.ADDR_WIDTH(AW)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write addr=%0h data=%0h",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(bus.imem_addr), 64'(e.a));
        chk("wr_data", 64'(bus.imem_wdata), 64'(e.d));
      end
      wr_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input int n, input int gap);
    logic [31:0] v;
    v = 32'(n);
    for (int k = 0; k < 4; k++) send_byte(v[31-8*k -: 8], gap);
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    chk("rl_led", 64'(bus.led), 64'h1);
    chk("rl_cpu", 64'(bus.cpu_rst_n), 64'h0);
    chk("rl_wc", 64'(bus.word_count), 64'h0);
    chk("rl_addr", 64'(bus.imem_addr), 64'h0);
    chk("rl_we", 64'(bus.imem_we), 64'h0);
  endtask

  // Sends one payload word; expectation is queued before its last byte
  task automatic send_word(input int idx, input logic [31:0] d,
                           input int gap, inout logic [7:0] x);
    wr_t e;
    for (int k = 0; k < 4; k++) begin
      x = x ^ d[31-8*k -: 8];
      if (k == 3) begin
        e.a = idx[AW-1:0];
        e.d = d;
        sb.push_back(e);
      end
      send_byte(d[31-8*k -: 8], gap);
    end
  endtask

  task automatic finish_image(input int n, input logic [7:0] x);
`ifdef BOOT_LOAD_CHECKSUM_EN
    chk("chk_led", 64'(bus.led), 64'h4);
    chk("chk_cpu", 64'(bus.cpu_rst_n), 64'h0);
    send_byte(x, 0);
`else
    if (n > 0) chk("last_we", 64'(bus.imem_we), 64'h1);
    chk("no_ck_x", 64'(x), 64'(x));
`endif
    chk("run_led", 64'(bus.led), 64'h8);
    chk("run_hold", 64'(bus.cpu_rst_n), 64'h0);
    chk("run_wc", 64'(bus.word_count), 64'(n));
    tick();
    chk("cpu_rel", 64'(bus.cpu_rst_n), 64'h1);
    chk("we_low", 64'(bus.imem_we), 64'h0);
    chk("sb_empty", 64'(sb.size()), 64'h0);
  endtask

  task automatic run_image(input int n, input int gap);
    logic [7:0] x;
    x = 8'd0;
    send_hdr(n, gap);
    for (int w = 0; w < n; w++) send_word(w, $urandom, gap, x);
    finish_image(n, x);
  endtask

  task automatic check_err();
    chk("err_led", 64'(bus.led), 64'hf);
    chk("err_cpu", 64'(bus.cpu_rst_n), 64'h0);
    chk("err_wc", 64'(bus.word_count), 64'h0);
  endtask

  initial begin
    logic [7:0] x;
    int n;
    int g;
    total = 0;
    bad   = 0;
    cyc   = 0;
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    bus.reload   = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_led", 64'(bus.led), 64'h1);
    chk("rst_cpu", 64'(bus.cpu_rst_n), 64'h0);
    chk("rst_we", 64'(bus.imem_we), 64'h0);
    chk("rst_addr", 64'(bus.imem_addr), 64'h0);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'h0);
    chk("rst_wc", 64'(bus.word_count), 64'h0);
    #9 rst_n = 1'b1;
    tick();

    // Directed two-word image
    x = 8'd0;
    send_hdr(2, 0);
    send_word(0, 32'h11223344, 0, x);
    send_word(1, 32'hAABBCCDD, 0, x);
    finish_image(2, x);
    chk("hold_addr", 64'(bus.imem_addr), 64'h1);
    chk("hold_data", 64'(bus.imem_wdata), 64'hAABBCCDD);
    send_byte(8'h55, 0);
    send_byte(8'h66, 1);
    chk("run_ign_led", 64'(bus.led), 64'h8);
    chk("run_ign_wc", 64'(bus.word_count), 64'h2);
    pulse_reload();

    // Empty image
    run_image(0, 0);
    pulse_reload();
`ifdef BOOT_LOAD_CHECKSUM_EN
    send_hdr(0, 0);
    send_byte(8'h5A, 0);
    check_err();
    pulse_reload();
`endif

    // Over capacity, then exact capacity
    send_hdr(17, 0);
    check_err();
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 0);
    check_err();
    pulse_reload();
    run_image(16, 0);
    pulse_reload();

    // Reload mid-load
    x = 8'd0;
    send_hdr(2, 1);
    send_word(0, $urandom, 0, x);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    pulse_reload();
    x = 8'd0;
    send_hdr(1, 0);
    send_word(0, 32'hDEADBEEF, 0, x);
    finish_image(1, x);
    pulse_reload();

    // Asynchronous reset mid-word
    x = 8'd0;
    send_hdr(1, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", 64'(bus.led), 64'h1);
    chk("arst_cpu", 64'(bus.cpu_rst_n), 64'h0);
    chk("arst_wdata", 64'(bus.imem_wdata), 64'h0);
    chk("arst_addr", 64'(bus.imem_addr), 64'h0);
    chk("arst_wc", 64'(bus.word_count), 64'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    run_image(1, 0);
    pulse_reload();

    // Back-to-back strobes: writes 4 cycles apart
    wr_cyc.delete();
    run_image(3, 0);
    chk("b2b_cnt", 64'(wr_cyc.size()), 64'h3);
    if (wr_cyc.size() == 3) begin
      chk("b2b_gap0", 64'(wr_cyc[1] - wr_cyc[0]), 64'h4);
      chk("b2b_gap1", 64'(wr_cyc[2] - wr_cyc[1]), 64'h4);
    end
    pulse_reload();

    // reload coinciding with rx_valid drops the byte
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b1;
    bus.reload   = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.reload   = 1'b0;
    chk("coll_led", 64'(bus.led), 64'h1);
    run_image(1, 0);
    pulse_reload();

    // Randomized images
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 18);
      g = $urandom_range(0, 2);
      if (n > 16) begin
        send_hdr(n, g);
        check_err();
        send_byte(8'($urandom), g);
        check_err();
      end else begin
        run_image(n, g);
      end
      pulse_reload();
    end

    repeat (3) tick();
    chk("final_sb", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_load_ctrl.md
Name: boot_load_ctrl

Overview:
- Boot-time sequencer between the UART receiver and the CPU core / instruction memory.
- Receives a length-prefixed program image over the UART byte stream, writes it word by word into instruction memory, then releases the core from reset.
- A reload request re-enters the load sequence at any time, holding the core in reset while the new image is written.

Parameters:
ADDR_WIDTH, 14, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
rx_data  input  8  received UART byte
rx_valid  input  1  one-cycle strobe; rx_data valid this cycle
reload  input  1  synchronous, already-debounced pulse; restart loading
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  instruction-memory word address
imem_wdata  output  32  instruction-memory write data
cpu_rst_n  output  1  active-low reset to the CPU core
led  output  4  state indicator
word_count  output  ADDR_WIDTH+1  number of words written in the current load

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=HDR; all outputs driven from registers.
  - imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, led=4'b0001, word_count=0.
  - Byte counter, header register and word index cleared.
- States: HDR, LOAD, CHK (only with the optional feature), RUN, ERR.
- led encoding: HDR=0001, LOAD=0010, CHK=0100, RUN=1000, ERR=1111.
- Byte assembly:
  - A 2-bit byte counter advances on each accepted rx_valid in HDR, LOAD and CHK.
  - Bytes are big-endian: the first byte goes to bits [31:24].
  - The counter wraps 3->0 when a word completes.
- HDR:
  - Collects 4 bytes into N, the 32-bit word count.
  - On the 4th byte:
    - N==0: go to RUN (CHK if the feature is enabled).
    - N>2^ADDR_WIDTH: go to ERR.
    - Otherwise: go to LOAD.
  - N==2^ADDR_WIDTH is legal.
- LOAD, on the cycle the 4th byte of a word is accepted:
  - The next edge registers imem_wdata=assembled word, imem_addr=index, imem_we=1.
  - On the same edge, index and word_count increment.
  - imem_we is high for exactly one cycle.
  - Back-to-back rx_valid strobes every cycle are legal; a write pulse every 4 bytes, no bytes lost.
- Last word (word_count reaches N):
  - Go to RUN (or CHK) on the same edge that raises imem_we.
  - cpu_rst_n rises on the next edge, i.e. one cycle after the final imem_we pulse.
- RUN: cpu_rst_n=1; rx_valid ignored.
- ERR: cpu_rst_n=0, imem_we=0; rx_valid ignored until reload.
- reload=1 in any state:
  - Next edge: state=HDR, cpu_rst_n=0, imem_we=0.
  - Byte counter, index and word_count cleared; imem_addr=0.
- reload and rx_valid in the same cycle: reload wins and the byte is dropped.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- word_count saturates by construction; it never exceeds N.

Optional Feature:
- Macro: BOOT_LOAD_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR is kept over all payload bytes; header bytes are excluded.
  - The XOR clears on entry to HDR.
  - After the last word the state is CHK; the next accepted byte is compared with the XOR.
  - Match: go to RUN; cpu_rst_n rises on the edge after the compare.
  - Mismatch: go to ERR.
  - N==0: expected checksum is 0x00.
- Undefined:
  - CHK state, XOR register and compare logic are absent.
  - The last word goes directly to RUN; led never shows 0100.

Test Plan:
1. Header 00 00 00 02, then bytes 11 22 33 44 AA BB CC DD -> imem_we pulses: addr0=0x11223344, addr1=0xAABBCCDD; word_count=2; cpu_rst_n=1 one cycle after the second pulse; led=1000.
2. Header 00 00 00 00 -> no imem_we; RUN (feature off); with the feature on, byte 00 -> RUN and byte 5A -> ERR.
3. ADDR_WIDTH=4, header 00 00 00 11 (N=17) -> ERR, led=1111, no writes; further bytes ignored; reload -> HDR, led=0001.
4. Mid-LOAD after 6 payload bytes, reload pulse -> HDR, cpu_rst_n=0, word_count=0; a new header 00 00 00 01 plus word DEADBEEF -> write at addr0.
5. Assert RST_N low mid-word -> outputs take reset values immediately, without waiting for CLK; after release, a fresh header is required; the partial word is discarded.
6. rx_valid every cycle for header 00 00 00 03 plus 12 payload bytes -> exactly 3 writes at addr 0, 1, 2, each 4 cycles apart; rx_valid coinciding with reload -> byte dropped, HDR byte counter=0.
